csr_trap_unit: RTL

Parametrised machine-mode CSR file with an integrated trap sequencer, replacing the single-width CSR block in the execute stage. It holds the M-mode CSRs, counts cycles and retired instructions with inhibit control, and arbitrates prioritised interrupts (timer, software, external, plus `NUM_IRQ` platform lines). It supports direct and vectored `mtvec`, and issues a one-cycle PC redirect to fetch on trap entry and on `mret`.

---
 rtl/csr_trap_unit_if.sv | 44 ++++
 rtl/csr_trap_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit_if.sv
// ============================================================================
// Module      : csr_trap_unit_if
// Description : Pipeline-side bus of the M-mode CSR file and trap sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface csr_trap_unit_if #(
  parameter int XLEN    = 64,
  parameter int NUM_IRQ = 4
) ();
  logic               inst_valid;
  logic [XLEN-1:0]    inst_addr;
  logic [11:0]        csr_index;
  logic [1:0]         csr_op;
  logic [XLEN-1:0]    csr_wdata;
  logic               inst_ecall;
  logic               inst_ebreak;
  logic               inst_mret;
  logic               irq_mtip;
  logic               irq_msip;
  logic               irq_meip;
  logic [NUM_IRQ-1:0] irq_local;
  logic [XLEN-1:0]    csr_rdata;
  logic               csr_busy;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;

  modport master (
    output inst_valid, inst_addr, csr_index, csr_op, csr_wdata,
           inst_ecall, inst_ebreak, inst_mret,
           irq_mtip, irq_msip, irq_meip, irq_local,
    input  csr_rdata, csr_busy, redirect_valid, redirect_pc
  );

  modport slave (
    input  inst_valid, inst_addr, csr_index, csr_op, csr_wdata,
           inst_ecall, inst_ebreak, inst_mret,
           irq_mtip, irq_msip, irq_meip, irq_local,
    output csr_rdata, csr_busy, redirect_valid, redirect_pc
  );
endinterface

`default_nettype wire

// File: rtl/csr_trap_unit.sv
// ============================================================================
// Module      : csr_trap_unit
// Description : Machine-mode CSR file with counters, prioritised interrupts
//               and a trap/mret redirect sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module csr_trap_unit #(
  parameter int              XLEN        = 64,
  parameter int              NUM_IRQ     = 4,
  parameter logic [XLEN-1:0] RESET_MTVEC = 'h80000000,
  parameter int              HART_ID     = 0
) (
  input  wire logic           clk,
  input  wire logic           rst,
  csr_trap_unit_if.slave      bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_TRAP = 2'd1, S_RET = 2'd2} state_t;

  function automatic logic [XLEN-1:0] f_mie_mask();
    logic [XLEN-1:0] m;
    m     = '0;
    m[3]  = 1'b1;
    m[7]  = 1'b1;
    m[11] = 1'b1;
    for (int k = 0; k < NUM_IRQ; k++) m[16+k] = 1'b1;
    return m;
  endfunction

  localparam logic [XLEN-1:0] c_mie_mask = f_mie_mask();

  state_t          r_state, w_state_nxt;
  logic            r_mstatus_mie, r_mstatus_mpie;
  logic [XLEN-1:0] r_mie, r_mip, r_mtvec, r_mcountinhibit, r_mscratch;
  logic [XLEN-1:0] r_mepc, r_mcause, r_mcycle, r_minstret;

  logic [XLEN-1:0] w_mstatus, w_misa, w_irq_vec, w_pend, w_rdata, w_wval;
  logic [XLEN-1:0] w_trap_base, w_trap_target, w_cause, w_redirect_pc;
  logic            w_impl, w_illegal, w_accept, w_trap, w_we, w_ret;
  logic            w_irq_any, w_redirect_valid, w_busy;
  logic [4:0]      w_code;

  always_comb begin
    w_mstatus        = '0;
    w_mstatus[12:11] = 2'b11;
    w_mstatus[7]     = r_mstatus_mpie;
    w_mstatus[3]     = r_mstatus_mie;
    w_misa                  = '0;
    w_misa[XLEN-1:XLEN-2]   = (XLEN == 64) ? 2'b10 : 2'b01;
    w_misa[8]               = 1'b1;
    w_irq_vec     = '0;
    w_irq_vec[3]  = bus.irq_msip;
    w_irq_vec[7]  = bus.irq_mtip;
    w_irq_vec[11] = bus.irq_meip;
    for (int k = 0; k < NUM_IRQ; k++) w_irq_vec[16+k] = bus.irq_local[k];
  end

  always_comb begin
    w_rdata = '0;
    w_impl  = 1'b1;
    case (bus.csr_index)
      12'h300: w_rdata = w_mstatus;
      12'h301: w_rdata = w_misa;
      12'h304: w_rdata = r_mie;
      12'h305: w_rdata = r_mtvec;
      12'h320: w_rdata = r_mcountinhibit;
      12'h340: w_rdata = r_mscratch;
      12'h341: w_rdata = r_mepc;
      12'h342: w_rdata = r_mcause;
      12'h344: w_rdata = r_mip;
      12'hB00: w_rdata = r_mcycle;
      12'hB02: w_rdata = r_minstret;
      12'hF11: w_rdata = '0;
      12'hF12: w_rdata = XLEN'(1);
      12'hF13: w_rdata = '0;
      12'hF14: w_rdata = XLEN'(HART_ID);
      default: w_impl  = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.csr_op)
      2'b01:   w_wval = bus.csr_wdata;
      2'b10:   w_wval = w_rdata | bus.csr_wdata;
      2'b11:   w_wval = w_rdata & ~bus.csr_wdata;
      default: w_wval = w_rdata;
    endcase
  end

  assign w_illegal = (bus.csr_op != 2'b00) && (!w_impl || bus.csr_index[11:10] == 2'b11);
  assign w_pend    = r_mip & r_mie & {XLEN{r_mstatus_mie}};
  assign w_irq_any = |w_pend;

  // Interrupts outrank exceptions; among locals the lowest index wins.
  always_comb begin
    w_code = 5'd0;
    if (w_pend[11])      w_code = 5'd11;
    else if (w_pend[3])  w_code = 5'd3;
    else if (w_pend[7])  w_code = 5'd7;
    else if (w_irq_any) begin
      for (int k = NUM_IRQ - 1; k >= 0; k--)
        if (w_pend[16+k]) w_code = 5'(16 + k);
    end
    else if (w_illegal)       w_code = 5'd2;
    else if (bus.inst_ecall)  w_code = 5'd11;
    else if (bus.inst_ebreak) w_code = 5'd3;
    w_cause         = XLEN'(w_code);
    w_cause[XLEN-1] = w_irq_any;
  end

  assign w_accept = bus.inst_valid && (r_state == S_IDLE);
  assign w_trap   = w_accept && (w_irq_any || w_illegal || bus.inst_ecall || bus.inst_ebreak);
  assign w_we     = w_accept && !w_trap && (bus.csr_op != 2'b00);
  assign w_ret    = w_accept && !w_trap && bus.inst_mret;

  assign w_trap_base   = {r_mtvec[XLEN-1:2], 2'b00};
  assign w_trap_target = (r_mtvec[0] && r_mcause[XLEN-1])
                       ? w_trap_base + {r_mcause[XLEN-3:0], 2'b00} : w_trap_base;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = '0;
    w_busy           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trap)     w_state_nxt = S_TRAP;
        else if (w_ret) w_state_nxt = S_RET;
      end
      S_TRAP: begin
        w_redirect_valid = 1'b1;
        w_busy           = 1'b1;
        w_redirect_pc    = w_trap_target;
        w_state_nxt      = S_IDLE;
      end
      S_RET: begin
        w_redirect_valid = 1'b1;
        w_busy           = 1'b1;
        w_redirect_pc    = r_mepc;
        w_state_nxt      = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mstatus_mie   <= 1'b0;
      r_mstatus_mpie  <= 1'b0;
      r_mie           <= '0;
      r_mip           <= '0;
      r_mtvec         <= RESET_MTVEC & ~XLEN'(3);
      r_mcountinhibit <= '0;
      r_mscratch      <= '0;
      r_mepc          <= '0;
      r_mcause        <= '0;
    end else begin
      r_mip <= w_irq_vec;
      // A trap cancels the instruction, so its CSR write never lands.
      if (w_trap) begin
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
        r_mepc         <= bus.inst_addr & ~XLEN'(3);
        r_mcause       <= w_cause;
      end else if (w_ret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_we) begin
        case (bus.csr_index)
          12'h300: begin
            r_mstatus_mie  <= w_wval[3];
            r_mstatus_mpie <= w_wval[7];
          end
          12'h304: r_mie           <= w_wval & c_mie_mask;
          12'h305: r_mtvec         <= w_wval & ~XLEN'(2);
          12'h320: r_mcountinhibit <= w_wval & XLEN'(5);
          12'h340: r_mscratch      <= w_wval;
          12'h341: r_mepc          <= w_wval & ~XLEN'(3);
          12'h342: r_mcause        <= w_wval;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_we && bus.csr_index == 12'hB00)      r_mcycle <= w_wval;
      else if (!r_mcountinhibit[0])              r_mcycle <= r_mcycle + 1'b1;
      if (w_we && bus.csr_index == 12'hB02)      r_minstret <= w_wval;
      else if (w_accept && !w_trap && !r_mcountinhibit[2])
                                                 r_minstret <= r_minstret + 1'b1;
    end
  end

  assign bus.csr_rdata      = w_rdata;
  assign bus.csr_busy       = w_busy;
  assign bus.redirect_valid = w_redirect_valid;
  assign bus.redirect_pc    = w_redirect_pc;

endmodule

`default_nettype wire
